// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage PC sequencing, I-cache request tracking, redirect deferral and stall buffer
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   imem_resp_i, imem_rdata_i          I-cache response valid / read data
//   btb_hit_i                          BTB hit for the current fetch PC (valid with response)
//   stall_i                            decode cannot accept an instruction this cycle
//   redir_valid_i/sel_i/target_i       EX-stage redirect request, pcmux source and operand
//   load_pc_o, pcmux_sel_o             PC register load enable and next-PC source
//   instr_read_o                       I-cache read request (address = PC)
//   held_valid_o, held_target_o        substitute the latched redirect operand at the PC mux
//   if_valid_o, if_instr_o, if_btb_hit_o  instruction, valid and prediction tag to IF/ID
//   flush_if_id_o                      squash the IF/ID register
module fetch_ctrl #(
   parameter int XLEN  = 32,
   parameter int SEL_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             imem_resp_i,
   input  logic [XLEN-1:0]  imem_rdata_i,
   input  logic             btb_hit_i,
   input  logic             stall_i,
   input  logic             redir_valid_i,
   input  logic [SEL_W-1:0] redir_sel_i,
   input  logic [XLEN-1:0]  redir_target_i,
   output logic             load_pc_o,
   output logic [SEL_W-1:0] pcmux_sel_o,
   output logic             instr_read_o,
   output logic             held_valid_o,
   output logic [XLEN-1:0]  held_target_o,
   output logic             if_valid_o,
   output logic [XLEN-1:0]  if_instr_o,
   output logic             if_btb_hit_o,
   output logic             flush_if_id_o
);
   localparam logic [SEL_W-1:0] SEL_PLUS4 = SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_BTB   = SEL_W'(4);

   typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [XLEN-1:0]  buf_instr_q, buf_instr_d;
   logic             buf_btb_q, buf_btb_d;
   logic [SEL_W-1:0] lat_sel_q, lat_sel_d;
   logic [XLEN-1:0]  lat_tgt_q, lat_tgt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= BOOT;
         buf_instr_q <= '0;
         buf_btb_q   <= 1'b0;
         lat_sel_q   <= '0;
         lat_tgt_q   <= '0;
      end else begin
         state_q     <= state_d;
         buf_instr_q <= buf_instr_d;
         buf_btb_q   <= buf_btb_d;
         lat_sel_q   <= lat_sel_d;
         lat_tgt_q   <= lat_tgt_d;
      end
   end

   // The latched operand is always visible; held_valid_o says when the PC mux must use it.
   assign held_target_o = lat_tgt_q;

   always_comb begin
      state_d       = state_q;
      buf_instr_d   = buf_instr_q;
      buf_btb_d     = buf_btb_q;
      lat_sel_d     = lat_sel_q;
      lat_tgt_d     = lat_tgt_q;
      load_pc_o     = 1'b0;
      pcmux_sel_o   = SEL_PLUS4;
      instr_read_o  = 1'b0;
      held_valid_o  = 1'b0;
      if_valid_o    = 1'b0;
      if_instr_o    = '0;
      if_btb_hit_o  = 1'b0;
      flush_if_id_o = 1'b0;
      case (state_q)
         // Any response seen here belongs to a request issued before reset.
         BOOT: state_d = FETCH;
         FETCH: begin
            instr_read_o = 1'b1;
            if (redir_valid_i) begin
               flush_if_id_o = 1'b1;
               if (imem_resp_i) begin
                  load_pc_o   = 1'b1;
                  pcmux_sel_o = redir_sel_i;
               end else begin
                  // Request still in flight: PC must stay put until it returns.
                  lat_sel_d = redir_sel_i;
                  lat_tgt_d = redir_target_i;
                  state_d   = DRAIN;
               end
            end else if (imem_resp_i) begin
               if (stall_i) begin
                  buf_instr_d = imem_rdata_i;
                  buf_btb_d   = btb_hit_i;
                  state_d     = HOLD;
               end else begin
                  if_valid_o   = 1'b1;
                  if_instr_o   = imem_rdata_i;
                  if_btb_hit_o = btb_hit_i;
                  load_pc_o    = 1'b1;
                  pcmux_sel_o  = btb_hit_i ? SEL_BTB : SEL_PLUS4;
               end
            end
         end
         HOLD: begin
            if_valid_o   = !redir_valid_i;
            if_instr_o   = buf_instr_q;
            if_btb_hit_o = buf_btb_q;
            if (redir_valid_i) begin
               flush_if_id_o = 1'b1;
               load_pc_o     = 1'b1;
               pcmux_sel_o   = redir_sel_i;
               state_d       = FETCH;
            end else if (!stall_i) begin
               load_pc_o   = 1'b1;
               pcmux_sel_o = buf_btb_q ? SEL_BTB : SEL_PLUS4;
               state_d     = FETCH;
            end
         end
         DRAIN: begin
            instr_read_o = 1'b1;
            if (redir_valid_i) begin
               // A younger redirect replaces the deferred one.
               flush_if_id_o = 1'b1;
               lat_sel_d     = redir_sel_i;
               lat_tgt_d     = redir_target_i;
            end
            if (imem_resp_i) begin
               load_pc_o    = 1'b1;
               held_valid_o = !redir_valid_i;
               pcmux_sel_o  = redir_valid_i ? redir_sel_i : lat_sel_q;
               state_d      = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end
endmodule
